// File: rtl/vickrey_auction_sequencer_if.sv
// Bus bundle for vickrey_auction_sequencer.
//   master : bid-collection side, drives start/bids/active and observes results
//   slave  : the sequencer itself
// Signals:
//   start   - begin an auction (honoured only when the sequencer is idle)
//   bids    - flattened bids, bidder k at [W*k+W-1 : W*k]
//   active  - per-bidder participation mask
//   sel     - current scan index (shared bid mux select)
//   busy    - scan in progress
//   done    - one-cycle pulse when results become valid
//   found   - at least one nonzero effective bid was seen
//   winner  - winning bidder index
//   grant   - one-hot winner, all-zero when nothing was found
//   win_bid - highest effective bid
//   price   - second-highest effective bid
interface vickrey_auction_sequencer_if #(
    parameter int N = 3,
    parameter int W = 8
);
    logic                  start;
    logic [W*(2**N)-1:0]   bids;
    logic [(2**N)-1:0]     active;
    logic [N-1:0]          sel;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [N-1:0]          winner;
    logic [(2**N)-1:0]     grant;
    logic [W-1:0]          win_bid;
    logic [W-1:0]          price;

    modport master (
        output start, bids, active,
        input  sel, busy, done, found, winner, grant, win_bid, price
    );

    modport slave (
        input  start, bids, active,
        output sel, busy, done, found, winner, grant, win_bid, price
    );
endinterface

// File: rtl/vickrey_auction_sequencer.sv
// Sequential second-price (Vickrey) auction controller for 2**N bidders.
// Latches all bids on start, then scans one bidder per clock, tracking the
// highest bid, the second-highest bid (the price) and the winner index.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - vickrey_auction_sequencer_if slave modport (see interface header)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | results of last auction held, waiting for start
// SCAN  | one bidder compared per cycle, sel = bidder under test
// DONE  | done pulse, results valid, returns to IDLE unconditionally
module vickrey_auction_sequencer #(
    parameter int N = 3,
    parameter int W = 8
) (
    input logic                         clk,
    input logic                         rst,
    vickrey_auction_sequencer_if.slave  bus
);
    localparam int NB = 2**N;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 state;
    logic [NB-1:0][W-1:0]   bid_q;
    logic [NB-1:0]          active_q;
    logic [N-1:0]           sel_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   found_q;
    logic [N-1:0]           winner_q;
    logic [W-1:0]           win_bid_q;
    logic [W-1:0]           price_q;
    logic [W-1:0]           eff_bid;

    // Masked-out bidders participate with an effective bid of zero.
    assign eff_bid = active_q[sel_q] ? bid_q[sel_q] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bid_q     <= '0;
            active_q  <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            winner_q  <= '0;
            win_bid_q <= '0;
            price_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        bid_q     <= bus.bids;
                        active_q  <= bus.active;
                        win_bid_q <= '0;
                        price_q   <= '0;
                        winner_q  <= '0;
                        found_q   <= 1'b0;
                        sel_q     <= '0;
                        busy_q    <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict compare: the lowest index among equal maxima keeps
                    // the win and the equal later bid becomes the price.
                    if (eff_bid > win_bid_q) begin
                        price_q   <= win_bid_q;
                        win_bid_q <= eff_bid;
                        winner_q  <= sel_q;
                        found_q   <= 1'b1;
                    end else if (eff_bid > price_q) begin
                        price_q <= eff_bid;
                    end
                    sel_q <= sel_q + 1'b1;
                    if (&sel_q) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.found   = found_q;
    assign bus.winner  = winner_q;
    assign bus.win_bid = win_bid_q;
    assign bus.price   = price_q;
    assign bus.grant   = found_q ? ({{(NB-1){1'b0}}, 1'b1} << winner_q) : '0;

endmodule
